// File: rtl/instr_type_stats_pkg.sv
// Shared definitions for the retired-instruction type statistics block:
// read-select encodings, default counter width and the type classifier.
package instr_type_stats_pkg;

  localparam int unsigned DEFAULT_CNT_W = 32;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned N_CNT         = 5;

  localparam logic [SEL_W-1:0] SEL_TOTAL = 3'd0;
  localparam logic [SEL_W-1:0] SEL_R     = 3'd1;
  localparam logic [SEL_W-1:0] SEL_I     = 3'd2;
  localparam logic [SEL_W-1:0] SEL_J     = 3'd3;
  localparam logic [SEL_W-1:0] SEL_OTHER = 3'd4;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_J,
    CLS_OTHER
  } instr_cls_e;

  // Exactly one flag selects its type; none or several fall into "other".
  function automatic instr_cls_e classify(input logic r, input logic i, input logic j);
    instr_cls_e cls;
    case ({r, i, j})
      3'b100:  cls = CLS_R;
      3'b010:  cls = CLS_I;
      3'b001:  cls = CLS_J;
      default: cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_type_stats_if.sv
// Retire/control/read-back bundle between the writeback side and the stats block.
interface instr_type_stats_if
  import instr_type_stats_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
);

  logic             retire;
  logic             i;
  logic             r;
  logic             j;
  logic             freeze;
  logic             clear;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] rdata;
  logic             sat;

  modport master (
    output retire, i, r, j, freeze, clear, sel,
    input  rdata, sat
  );

  modport slave (
    input  retire, i, r, j, freeze, clear, sel,
    output rdata, sat
  );

endinterface

// File: rtl/instr_type_stats_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

  assign at_max = (q == MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_type_stats.sv
// Per-type retired-instruction counters (total, R, I, J, other) with a
// registered read-back mux and a sticky saturation flag.
module instr_type_stats
  import instr_type_stats_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  instr_type_stats_if.slave  bus
);

  localparam logic [CNT_W-1:0] NEAR_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

  logic             count_en;
  instr_cls_e       cls;
  logic [N_CNT-1:0] inc;
  logic [N_CNT-1:0] at_max;
  logic [N_CNT-1:0] hit;
  logic [CNT_W-1:0] q [N_CNT];
  logic [CNT_W-1:0] rdata_d;
  logic [CNT_W-1:0] rdata_q;
  logic             sat_q;

  // clear drops a coincident retire; freeze suppresses counting entirely.
  assign count_en = bus.retire & ~bus.freeze & ~bus.clear;

  always_comb begin
    cls = classify(bus.r, bus.i, bus.j);
    inc = '0;
    inc[SEL_TOTAL] = count_en;
    case (cls)
      CLS_R:   inc[SEL_R]     = count_en;
      CLS_I:   inc[SEL_I]     = count_en;
      CLS_J:   inc[SEL_J]     = count_en;
      default: inc[SEL_OTHER] = count_en;
    endcase
  end

  for (genvar k = 0; k < N_CNT; k++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (bus.clear),
      .inc    (inc[k]),
      .q      (q[k]),
      .at_max (at_max[k])
    );

    // Counter steps onto all-ones this edge, so sat registers alongside it.
    assign hit[k] = inc[k] & ~at_max[k] & (q[k] == NEAR_MAX);
  end

  always_comb begin
    rdata_d = '0;
    case (bus.sel)
      SEL_TOTAL: rdata_d = q[SEL_TOTAL];
      SEL_R:     rdata_d = q[SEL_R];
      SEL_I:     rdata_d = q[SEL_I];
      SEL_J:     rdata_d = q[SEL_J];
      SEL_OTHER: rdata_d = q[SEL_OTHER];
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      if (bus.clear) begin
        sat_q <= 1'b0;
      end else begin
        sat_q <= sat_q | (|hit);
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.sat   = sat_q;

endmodule
